// File: rtl/sintable_pkg.sv
// -----------------------------------------------------------------------------
// sintable_pkg
//
// Shared definitions for the sine/cosine NCO:
//   - default widths for the phase accumulator, table size and output samples
//   - quadrant encoding of the two phase MSBs and the symmetry helpers that
//     fold a full wave onto the stored quarter wave
//   - LAT, the input-to-output latency in clocks
//   - rom_entry(), the quarter-wave table formula
// -----------------------------------------------------------------------------
package sintable_pkg;

    localparam int PW_DEF    = 24;  // phase accumulator / tuning word width
    localparam int LGTBL_DEF = 10;  // log2 of table entries per full wave
    localparam int OW_DEF    = 12;  // signed output sample width

    // i_ce to o_valid latency in clocks.
    localparam int LAT = 3;

    localparam real PI = 3.14159265358979323846;

    // Two most significant bits of the truncated phase.
    typedef enum logic [1:0] {
        QUAD_0   = 2'd0,  // [0, pi/2)
        QUAD_90  = 2'd1,  // [pi/2, pi)
        QUAD_180 = 2'd2,  // [pi, 3pi/2)
        QUAD_270 = 2'd3   // [3pi/2, 2pi)
    } quad_t;

    // Sine runs backwards through the quarter table in the 2nd and 4th
    // quadrants; cosine uses the opposite direction in every quadrant.
    function automatic logic quad_mirror_sin(input quad_t q);
        return q inside {QUAD_90, QUAD_270};
    endfunction

    // Sine is negative in the lower half-plane.
    function automatic logic quad_sin_neg(input quad_t q);
        return q inside {QUAD_180, QUAD_270};
    endfunction

    // Cosine is negative in the left half-plane.
    function automatic logic quad_cos_neg(input quad_t q);
        return q inside {QUAD_90, QUAD_180};
    endfunction

    // Quarter-wave entry k, sampled at half-step offsets so that the table
    // never hits exactly 0 or full scale and mirrors without duplicates.
    function automatic int rom_entry(input int k, input int lgtbl, input int ow);
        real amp;
        real ang;
        amp = real'((1 << (ow - 1)) - 1);
        ang = 2.0 * PI * (real'(k) + 0.5) / real'(1 << lgtbl);
        return $rtoi(amp * $sin(ang) + 0.5);
    endfunction

endpackage

// File: rtl/sintable_qrom.sv
// -----------------------------------------------------------------------------
// sintable_qrom
//
// Quarter-wave sine magnitude ROM with two registered read ports on one clock.
// Holds 2^(LGTBL-2) unsigned entries of OW-1 bits.
//
// Contents are built from rom_entry() at elaboration, so the block does not
// depend on an external file. INIT_FILE names the equivalent hex image.
//
// Ports:
//   clk       - clock for both read ports
//   sin_addr  - read address, sine port
//   cos_addr  - read address, cosine port
//   sin_mag   - registered magnitude for sin_addr (one clock after address)
//   cos_mag   - registered magnitude for cos_addr (one clock after address)
// -----------------------------------------------------------------------------
module sintable_qrom
    import sintable_pkg::*;
#(
    parameter int    LGTBL     = LGTBL_DEF,
    parameter int    OW        = OW_DEF,
    parameter string INIT_FILE = "sintable_q.hex"
) (
    input  logic             clk,
    input  logic [LGTBL-3:0] sin_addr,
    input  logic [LGTBL-3:0] cos_addr,
    output logic [OW-2:0]    sin_mag,
    output logic [OW-2:0]    cos_mag
);

    localparam int DEPTH = 1 << (LGTBL - 2);

    logic [OW-2:0] rom_tbl [DEPTH];

    for (genvar k = 0; k < DEPTH; k++) begin : g_entry
        assign rom_tbl[k] = (OW-1)'(rom_entry(k, LGTBL, OW));
    end

    // NOTE: ROM data and its read registers have no reset; only control
    // state (valids, outputs) must come up known, and resetting the array
    // would stop it mapping onto block ROM.
    always_ff @(posedge clk) begin
        sin_mag <= rom_tbl[sin_addr];
        cos_mag <= rom_tbl[cos_addr];
    end

endmodule

// File: rtl/sintable_nco.sv
// -----------------------------------------------------------------------------
// sintable_nco
//
// Phase-accumulating NCO producing simultaneous sine and cosine samples from a
// quarter-wave ROM. Three-stage pipeline, one sample per enabled clock:
//   stage 1 : capture current phase decode (quadrant, mirrored addresses,
//             negate flags) and advance the accumulator
//   stage 2 : registered dual ROM read, negate flags travel alongside
//   stage 3 : apply sign, register outputs and o_valid
// i_ce in cycle N gives o_valid in cycle N+3 carrying sin(P)/cos(P) for the
// phase P that was current in cycle N.
//
// Ports:
//   i_clk       - system clock
//   i_reset_n   - asynchronous active-low reset
//   i_ce        - sample enable: emit current phase, advance accumulator
//   i_sync      - with i_ce, zero the next phase (current sample unaffected)
//   i_load_ftw  - load i_ftw into the tuning-word register (any cycle)
//   i_ftw       - unsigned frequency tuning word, modulo 2^PW
//   o_valid     - o_sin/o_cos carry a new sample this cycle
//   o_sin       - signed sine sample, holds when o_valid is low
//   o_cos       - signed cosine sample, holds when o_valid is low
// -----------------------------------------------------------------------------
module sintable_nco
    import sintable_pkg::*;
#(
    parameter int    PW        = PW_DEF,
    parameter int    LGTBL     = LGTBL_DEF,
    parameter int    OW        = OW_DEF,
    parameter string INIT_FILE = "sintable_q.hex"
) (
    input  logic          i_clk,
    input  logic          i_reset_n,
    input  logic          i_ce,
    input  logic          i_sync,
    input  logic          i_load_ftw,
    input  logic [PW-1:0] i_ftw,
    output logic          o_valid,
    output logic [OW-1:0] o_sin,
    output logic [OW-1:0] o_cos
);

    localparam int AW = LGTBL - 2;  // quarter-table address width

    // -------------------------------------------------------------------------
    // Phase accumulator and tuning word
    // -------------------------------------------------------------------------
    logic [PW-1:0] phase;
    logic [PW-1:0] ftw_r;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            phase <= '0;
            ftw_r <= '0;
        end else begin
            // NOTE: non-blocking assignments mean the accumulate below sees
            // the ftw_r from before this edge, so a load coinciding with i_ce
            // takes effect only on the following i_ce.
            if (i_ce) begin
                phase <= i_sync ? '0 : phase + ftw_r;
            end
            if (i_load_ftw) begin
                ftw_r <= i_ftw;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Phase decode: truncate to table resolution and fold onto a quarter wave
    // -------------------------------------------------------------------------
    logic [LGTBL-1:0] idx;
    quad_t            quad;
    logic [AW-1:0]    fine;
    logic             mirror;

    assign idx    = phase[PW-1 -: LGTBL];
    assign quad   = quad_t'(idx[LGTBL-1 -: 2]);
    assign fine   = idx[AW-1:0];
    assign mirror = quad_mirror_sin(quad);

    // -------------------------------------------------------------------------
    // Stage 1: decoded addresses and negate flags
    // -------------------------------------------------------------------------
    logic          s1_valid;
    logic [AW-1:0] s1_sin_addr;
    logic [AW-1:0] s1_cos_addr;
    logic          s1_sin_neg;
    logic          s1_cos_neg;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            s1_valid    <= 1'b0;
            s1_sin_addr <= '0;
            s1_cos_addr <= '0;
            s1_sin_neg  <= 1'b0;
            s1_cos_neg  <= 1'b0;
        end else begin
            s1_valid <= i_ce;
            if (i_ce) begin
                // Cosine is sine a quarter wave ahead, which reverses the
                // table direction relative to sine in every quadrant.
                s1_sin_addr <= mirror ? ~fine : fine;
                s1_cos_addr <= mirror ? fine : ~fine;
                s1_sin_neg  <= quad_sin_neg(quad);
                s1_cos_neg  <= quad_cos_neg(quad);
            end
        end
    end

    // -------------------------------------------------------------------------
    // Stage 2: ROM read, flags delayed to stay aligned with the data
    // -------------------------------------------------------------------------
    logic [OW-2:0] sin_mag;
    logic [OW-2:0] cos_mag;
    logic          s2_valid;
    logic          s2_sin_neg;
    logic          s2_cos_neg;

    sintable_qrom #(
        .LGTBL     (LGTBL),
        .OW        (OW),
        .INIT_FILE (INIT_FILE)
    ) u_qrom (
        .clk      (i_clk),
        .sin_addr (s1_sin_addr),
        .cos_addr (s1_cos_addr),
        .sin_mag  (sin_mag),
        .cos_mag  (cos_mag)
    );

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            s2_valid   <= 1'b0;
            s2_sin_neg <= 1'b0;
            s2_cos_neg <= 1'b0;
        end else begin
            s2_valid   <= s1_valid;
            s2_sin_neg <= s1_sin_neg;
            s2_cos_neg <= s1_cos_neg;
        end
    end

    // -------------------------------------------------------------------------
    // Stage 3: sign application and output registers
    // -------------------------------------------------------------------------
    // Magnitudes are at most 2^(OW-1)-1, so the zero-extended value is a
    // positive OW-bit number and its two's-complement negation cannot overflow.
    logic [OW-1:0] sin_ext;
    logic [OW-1:0] cos_ext;

    assign sin_ext = {1'b0, sin_mag};
    assign cos_ext = {1'b0, cos_mag};

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_valid <= 1'b0;
            o_sin   <= '0;
            o_cos   <= '0;
        end else begin
            o_valid <= s2_valid;
            if (s2_valid) begin
                o_sin <= s2_sin_neg ? -sin_ext : sin_ext;
                o_cos <= s2_cos_neg ? -cos_ext : cos_ext;
            end
        end
    end

endmodule

// File: tb/tb_sintable_nco.sv
// -----------------------------------------------------------------------------
// tb_sintable_nco
//
// Self-checking bench for sintable_nco at default widths. Stimulus tasks push
// the expected (sin, cos) pair for every enabled sample onto a scoreboard; a
// negedge monitor pops and compares whenever o_valid is high, and checks that
// outputs hold while o_valid is low. Expected samples come either from the
// test-plan constants or from a full-wave sine model evaluated directly from
// the phase.
// -----------------------------------------------------------------------------
module tb_sintable_nco;
    import sintable_pkg::*;

    localparam int PW    = 24;
    localparam int LGTBL = 10;
    localparam int OW    = 12;
    localparam int NTBL  = 1 << LGTBL;
    localparam int NCAP  = NTBL + 1;

    logic          i_clk      = 1'b0;
    logic          i_reset_n  = 1'b1;
    logic          i_ce       = 1'b0;
    logic          i_sync     = 1'b0;
    logic          i_load_ftw = 1'b0;
    logic [PW-1:0] i_ftw      = '0;
    logic          o_valid;
    logic [OW-1:0] o_sin;
    logic [OW-1:0] o_cos;

    always #5 i_clk = ~i_clk;

    sintable_nco #(
        .PW        (PW),
        .LGTBL     (LGTBL),
        .OW        (OW),
        .INIT_FILE ("")
    ) dut (
        .i_clk      (i_clk),
        .i_reset_n  (i_reset_n),
        .i_ce       (i_ce),
        .i_sync     (i_sync),
        .i_load_ftw (i_load_ftw),
        .i_ftw      (i_ftw),
        .o_valid    (o_valid),
        .o_sin      (o_sin),
        .o_cos      (o_cos)
    );

    typedef struct packed {
        logic [OW-1:0] s;
        logic [OW-1:0] c;
    } exp_t;

    exp_t sb[$];
    int   compared   = 0;
    int   mismatched = 0;

    // Bench-side model of the accumulator and tuning word.
    logic [PW-1:0] m_phase = '0;
    logic [PW-1:0] m_ftw   = '0;

    // Capture of emitted samples for the sweep symmetry checks.
    bit                   cap_en = 1'b0;
    int                   cap_n  = 0;
    logic signed [OW-1:0] cap_sin [NCAP];
    logic signed [OW-1:0] cap_cos [NCAP];

    // Burst tracking and hold checking.
    int            run_len  = 0;
    int            last_run = 0;
    logic [OW-1:0] last_sin = '0;
    logic [OW-1:0] last_cos = '0;

    localparam logic [OW-1:0] Q_SIN [4] = '{OW'(6), OW'(2047), OW'(-6), OW'(-2047)};
    localparam logic [OW-1:0] Q_COS [4] = '{OW'(2047), OW'(-6), OW'(-2047), OW'(6)};

    // sin(2*pi*(i+0.5)/NTBL) at full scale, rounded by magnitude.
    function automatic logic [OW-1:0] model_wave(input int i);
        real v;
        real amp;
        int  mag;
        amp = real'((1 << (OW - 1)) - 1);
        v   = amp * $sin(2.0 * 3.14159265358979 * (real'(i) + 0.5) / real'(NTBL));
        mag = $rtoi(((v < 0.0) ? -v : v) + 0.5);
        return (v < 0.0) ? OW'(-mag) : OW'(mag);
    endfunction

    function automatic exp_t model_sample(input logic [PW-1:0] p);
        int   i;
        exp_t e;
        i   = int'(p[PW-1 -: LGTBL]);
        e.s = model_wave(i);
        e.c = model_wave((i + NTBL / 4) % NTBL);
        return e;
    endfunction

    // -------------------------------------------------------------------------
    // Monitor / scoreboard
    // -------------------------------------------------------------------------
    always @(negedge i_clk) begin : monitor
        exp_t e;
        if (!i_reset_n) begin
            last_sin = '0;
            last_cos = '0;
            run_len  = 0;
        end else if (o_valid) begin
            run_len++;
            compared++;
            if (sb.size() == 0) begin
                mismatched++;
                $display("FAIL unexpected_valid: o_valid=1 (sin=%0d cos=%0d), required no sample outstanding",
                         $signed(o_sin), $signed(o_cos));
            end else begin
                e = sb.pop_front();
                if (o_sin !== e.s || o_cos !== e.c) begin
                    mismatched++;
                    $display("FAIL sample @%0t: got sin=%0d cos=%0d, required sin=%0d cos=%0d",
                             $time, $signed(o_sin), $signed(o_cos), $signed(e.s), $signed(e.c));
                end
            end
            if (cap_en && cap_n < NCAP) begin
                cap_sin[cap_n] = o_sin;
                cap_cos[cap_n] = o_cos;
                cap_n++;
            end
            last_sin = o_sin;
            last_cos = o_cos;
        end else begin
            if (run_len != 0) last_run = run_len;
            run_len = 0;
            compared++;
            if (o_sin !== last_sin || o_cos !== last_cos) begin
                mismatched++;
                $display("FAIL hold @%0t: got sin=%0d cos=%0d, required held sin=%0d cos=%0d",
                         $time, $signed(o_sin), $signed(o_cos), $signed(last_sin), $signed(last_cos));
            end
        end
    end

    // -------------------------------------------------------------------------
    // Stimulus helpers: one call occupies one clock
    // -------------------------------------------------------------------------
    task automatic apply(input logic ce, input logic sync, input logic load,
                         input logic [PW-1:0] ftw, input bit push,
                         input bit use_const, input logic [OW-1:0] es,
                         input logic [OW-1:0] ec);
        exp_t e;
        @(posedge i_clk);
        #1;
        i_ce       = ce;
        i_sync     = sync;
        i_load_ftw = load;
        i_ftw      = ftw;
        if (ce && push) begin
            if (use_const) begin
                e.s = es;
                e.c = ec;
            end else begin
                e = model_sample(m_phase);
            end
            sb.push_back(e);
        end
        if (ce) m_phase = sync ? '0 : m_phase + m_ftw;
        if (load) m_ftw = ftw;
    endtask

    task automatic drive(input logic ce, input logic sync, input logic load,
                         input logic [PW-1:0] ftw);
        apply(ce, sync, load, ftw, 1'b1, 1'b0, '0, '0);
    endtask

    task automatic drive_c(input logic ce, input logic sync, input logic load,
                           input logic [PW-1:0] ftw, input logic [OW-1:0] es,
                           input logic [OW-1:0] ec);
        apply(ce, sync, load, ftw, 1'b1, 1'b1, es, ec);
    endtask

    task automatic idle();
        apply(1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0, '0, '0);
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        idle();
        while (sb.size() != 0 && n < 100) begin
            @(negedge i_clk);
            n++;
        end
        compared++;
        if (sb.size() != 0) begin
            mismatched++;
            $display("FAIL %s_drain: %0d samples outstanding after %0d cycles, required 0",
                     name, sb.size(), n);
            sb.delete();
        end
        repeat (4) @(negedge i_clk);
    endtask

    // -------------------------------------------------------------------------
    // Tests
    // -------------------------------------------------------------------------
    task automatic test_reset();
        #2;
        i_reset_n = 1'b0;
        i_ce      = 1'b1;  // ignored while in reset
        m_phase   = '0;
        m_ftw     = '0;
        repeat (3) @(negedge i_clk);
        compared++;
        if (o_valid !== 1'b0) begin
            mismatched++;
            $display("FAIL reset_valid: o_valid=%b, required 0", o_valid);
        end
        compared++;
        if (o_sin !== '0 || o_cos !== '0) begin
            mismatched++;
            $display("FAIL reset_outputs: sin=%0d cos=%0d, required 0 0",
                     $signed(o_sin), $signed(o_cos));
        end
        i_ce      = 1'b0;
        i_reset_n = 1'b1;
    endtask

    // Phase 0 and ftw 0 are assumed on entry: one sample gives (6, 2047).
    task automatic test_first_sample(input string name);
        drive_c(1'b1, 1'b0, 1'b0, '0, OW'(6), OW'(2047));
        idle();
        for (int k = 1; k <= LAT + 1; k++) begin
            @(negedge i_clk);
            compared++;
            if (o_valid !== (k == LAT)) begin
                mismatched++;
                $display("FAIL %s_latency: o_valid=%b in cycle N+%0d, required %b",
                         name, o_valid, k, (k == LAT));
            end
        end
        wait_drain(name);
    endtask

    task automatic test_quarter_wave();
        drive(1'b0, 1'b0, 1'b1, 24'h400000);
        for (int i = 0; i < 8; i++) begin
            drive_c(1'b1, 1'b0, 1'b0, '0, Q_SIN[i % 4], Q_COS[i % 4]);
        end
        wait_drain("quarter");
        compared++;
        if (last_run !== 8) begin
            mismatched++;
            $display("FAIL back_to_back: burst of %0d valid cycles, required 8", last_run);
        end
    endtask

    task automatic test_sync();
        drive_c(1'b1, 1'b0, 1'b0, '0, Q_SIN[0], Q_COS[0]);
        drive_c(1'b1, 1'b0, 1'b0, '0, Q_SIN[1], Q_COS[1]);
        drive_c(1'b1, 1'b1, 1'b0, '0, Q_SIN[2], Q_COS[2]);
        drive_c(1'b1, 1'b0, 1'b0, '0, Q_SIN[0], Q_COS[0]);
        drive_c(1'b1, 1'b0, 1'b0, '0, Q_SIN[1], Q_COS[1]);
        drive(1'b0, 1'b1, 1'b0, '0);  // sync without ce has no effect
        drive_c(1'b1, 1'b0, 1'b0, '0, Q_SIN[2], Q_COS[2]);
        wait_drain("sync");
    endtask

    task automatic test_load_with_ce();
        drive(1'b1, 1'b1, 1'b0, '0);  // realign to phase 0
        drive_c(1'b1, 1'b0, 1'b1, 24'h800000, OW'(6), OW'(2047));
        drive_c(1'b1, 1'b0, 1'b0, '0, OW'(2047), OW'(-6));
        drive_c(1'b1, 1'b0, 1'b0, '0, OW'(-2047), OW'(6));
        wait_drain("load_ce");
    endtask

    task automatic test_reset_flush();
        for (int i = 0; i < 3; i++) begin
            apply(1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0, '0, '0);
        end
        @(negedge i_clk);
        i_reset_n = 1'b0;
        i_ce      = 1'b0;
        m_phase   = '0;
        m_ftw     = '0;
        #1;
        compared++;
        if (o_valid !== 1'b0 || o_sin !== '0 || o_cos !== '0) begin
            mismatched++;
            $display("FAIL flush_reset: valid=%b sin=%0d cos=%0d, required 0 0 0",
                     o_valid, $signed(o_sin), $signed(o_cos));
        end
        @(negedge i_clk);
        i_reset_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge i_clk);
            compared++;
            if (o_valid !== 1'b0 || o_sin !== '0 || o_cos !== '0) begin
                mismatched++;
                $display("FAIL flush_quiet: valid=%b sin=%0d cos=%0d at cycle %0d after release, required 0 0 0",
                         o_valid, $signed(o_sin), $signed(o_cos), k);
            end
        end
        test_first_sample("after_flush");
    endtask

    task automatic test_random();
        drive(1'b0, 1'b0, 1'b1, PW'($urandom));
        for (int i = 0; i < 60; i++) begin
            logic [PW-1:0] f;
            int            r;
            f = PW'($urandom);
            r = $urandom_range(0, 9);
            case (r)
                0:       drive(1'b1, 1'b1, 1'b0, '0);
                1:       drive(1'b1, 1'b0, 1'b1, f);
                2:       drive(1'b0, 1'b1, 1'b0, '0);
                3:       drive(1'b0, 1'b0, 1'b1, f);
                default: drive(1'b1, 1'b0, 1'b0, '0);
            endcase
        end
        drive(1'b0, 1'b0, 1'b1, '0);  // ftw 0: same sample repeats
        repeat (4) drive(1'b1, 1'b0, 1'b0, '0);
        wait_drain("random");
    endtask

    task automatic test_sweep();
        int maxabs;
        int v;
        drive(1'b0, 1'b0, 1'b1, PW'(1) << (PW - LGTBL));
        drive(1'b1, 1'b1, 1'b0, '0);
        wait_drain("sweep_align");
        cap_n  = 0;
        cap_en = 1'b1;
        repeat (NCAP) drive(1'b1, 1'b0, 1'b0, '0);
        wait_drain("sweep");
        cap_en = 1'b0;
        compared++;
        if (cap_n != NCAP) begin
            mismatched++;
            $display("FAIL sweep_count: captured %0d samples, required %0d", cap_n, NCAP);
        end else begin
            maxabs = 0;
            for (int n = 0; n < NTBL; n++) begin
                compared++;
                if (cap_sin[n] !== -cap_sin[(n + NTBL / 2) % NTBL]) begin
                    mismatched++;
                    $display("FAIL sweep_halfwave n=%0d: sin=%0d, required -(%0d)",
                             n, cap_sin[n], cap_sin[(n + NTBL / 2) % NTBL]);
                end
                compared++;
                if (cap_cos[n] !== cap_sin[(n + NTBL / 4) % NTBL]) begin
                    mismatched++;
                    $display("FAIL sweep_quadrature n=%0d: cos=%0d, required %0d",
                             n, cap_cos[n], cap_sin[(n + NTBL / 4) % NTBL]);
                end
                v = cap_sin[n];
                if (v < 0) v = -v;
                if (v > maxabs) maxabs = v;
            end
            compared++;
            if (maxabs != 2047) begin
                mismatched++;
                $display("FAIL sweep_peak: max |sin|=%0d, required 2047", maxabs);
            end
            compared++;
            if (cap_sin[NTBL] !== cap_sin[0] || cap_cos[NTBL] !== cap_cos[0]) begin
                mismatched++;
                $display("FAIL sweep_wrap: after wrap sin=%0d cos=%0d, required %0d %0d",
                         cap_sin[NTBL], cap_cos[NTBL], cap_sin[0], cap_cos[0]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_first_sample("first");
        test_quarter_wave();
        test_sync();
        test_load_with_ce();
        test_reset_flush();
        test_random();
        test_sweep();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
